mem_self_test_ctrl: RTL and testbench

//  Sequencer in front of the 1024x16 DPRAM. Owns the memory RD/WR/A/DIn strobes and shares them between

---
 rtl/mem_self_test_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mem_self_test_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_self_test_ctrl.sv
// DPRAM access sequencer: manual single reads/writes plus a 4-phase write/verify self test.
// Build option: define MEM_TEST_ERRCNT_EN to run all phases and count errors instead of aborting.
module mem_self_test_ctrl #(
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN = 16'hA5A5,
  parameter int                TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              ar,
  input  logic              start,
  input  logic              man_rd_req,
  input  logic              man_wr_req,
  input  logic [ADDR_W-1:0] man_addr,
  input  logic [DATA_W-1:0] man_din,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [15:0]       err_count
);

  typedef enum logic [2:0] {IDLE, MAN_RD, MAN_WR, W0, R0, W1, R1, FIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`ifdef MEM_TEST_ERRCNT_EN
  localparam bit ABORT = 1'b0;
`else
  localparam bit ABORT = 1'b1;
`endif

  state_t            state;
  logic              start_q, rd_q, wr_q;
  logic              start_e, rd_e, wr_e;
  logic [7:0]        tcnt;
  logic              err;
  logic              strobe, timed_out, last_addr, is_write, is_read, acc_err;
  logic [DATA_W-1:0] exp_data;

  assign start_e   = start & ~start_q;
  assign rd_e      = man_rd_req & ~rd_q;
  assign wr_e      = man_wr_req & ~wr_q;
  assign strobe    = mem_rd | mem_wr;
  assign timed_out = (tcnt == TO_LAST);
  assign last_addr = &mem_a;
  assign is_write  = (state == W0) || (state == W1);
  assign is_read   = (state == R0) || (state == R1);

  // Expected word for the current address; inverted in the second half of the test.
  always_comb begin
    exp_data = PATTERN ^ DATA_W'(mem_a);
    if (state == W1 || state == R1) exp_data = ~exp_data;
  end

  // Evaluated only when the access ends: either done never came, or read data mismatched.
  assign acc_err = !mem_done || (is_read && (mem_dout != exp_data));

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      tcnt      <= '0;
      err       <= 1'b0;
      mem_a     <= '0;
      mem_din   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else begin
      start_q <= start;
      rd_q    <= man_rd_req;
      wr_q    <= man_wr_req;
      case (state)
        IDLE: begin
          if (start_e) begin
            state     <= W0;
            busy      <= 1'b1;
            mem_a     <= '0;
            mem_din   <= PATTERN;
            mem_wr    <= 1'b1;
            tcnt      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
          end else if (wr_e) begin
            state   <= MAN_WR;
            busy    <= 1'b1;
            mem_a   <= man_addr;
            mem_din <= man_din;
            mem_wr  <= 1'b1;
            tcnt    <= '0;
          end else if (rd_e) begin
            state  <= MAN_RD;
            busy   <= 1'b1;
            mem_a  <= man_addr;
            mem_rd <= 1'b1;
            tcnt   <= '0;
          end
        end
        MAN_RD, MAN_WR: begin
          if (mem_done || timed_out) begin
            if (mem_done && state == MAN_RD) rd_data <= mem_dout;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        W0, R0, W1, R1: begin
          if (!strobe) begin
            // Strobe was dropped last cycle; that cycle is the mandatory gap.
            tcnt <= '0;
            if (is_write) begin
              mem_wr  <= 1'b1;
              mem_din <= exp_data;
            end else begin
              mem_rd <= 1'b1;
            end
          end else if (mem_done || timed_out) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (acc_err) begin
              if (!err) fail_addr <= mem_a;
              if (!ABORT && err_count != '1) err_count <= err_count + 16'd1;
              err <= 1'b1;
            end
            if (acc_err && ABORT) begin
              state <= FIN;
            end else if (last_addr) begin
              mem_a <= '0;
              case (state)
                W0:      state <= R0;
                R0:      state <= W1;
                W1:      state <= R1;
                default: state <= FIN;
              endcase
            end else begin
              mem_a <= mem_a + 1'b1;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          pass  <= ~err;
          fail  <= err;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_self_test_ctrl.sv
// Bench for mem_self_test_ctrl: randomized-latency DPRAM model with fault injection,
// and an array-based reference of the whole self test.
module tb_mem_self_test_ctrl;

  logic        clk = 1'b0;
  logic        ar, start, man_rd_req, man_wr_req;
  logic [9:0]  man_addr;
  logic [15:0] man_din;
  logic        mem_done = 1'b0;
  logic [15:0] mem_dout = '0;
  logic [9:0]  mem_a, fail_addr;
  logic [15:0] mem_din, rd_data, err_count;
  logic        mem_rd, mem_wr, busy, done, pass, fail;

  int errors = 0;
  int checks = 0;

  bit          corrupt_en = 1'b0, hang_en = 1'b0;
  logic [9:0]  corrupt_addr = '0, hang_addr = '0;
  logic [15:0] mem [1024] = '{default: '0};
  logic [26:0] obs_q [$];
  logic [26:0] exp_q [$];
  bit          clr = 1'b0;
  int          k = 0, hi_len = 0, max_len = 0, wcnt = 0, lat = 0;
  logic        prev_strobe = 1'b0;
  int          n_err;
  logic [9:0]  faddr;
  logic [2:0]  last_flags = 3'b000;

  always #5 clk = ~clk;

  mem_self_test_ctrl dut (
    .clk        (clk),
    .ar         (ar),
    .start      (start),
    .man_rd_req (man_rd_req),
    .man_wr_req (man_wr_req),
    .man_addr   (man_addr),
    .man_din    (man_din),
    .mem_done   (mem_done),
    .mem_dout   (mem_dout),
    .mem_a      (mem_a),
    .mem_din    (mem_din),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_addr  (fail_addr),
    .err_count  (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DPRAM model: done after 1-2 cycles; k-1 is the index of the current self-test access.
  always @(posedge clk) begin
    if ((mem_rd || mem_wr) && !mem_done) begin
      if (!(hang_en && (k - 1) == int'(hang_addr))) begin
        if (wcnt >= lat) begin
          mem_done <= 1'b1;
          wcnt     <= 0;
          lat      <= ($urandom_range(3) == 0) ? 1 : 0;
          if (mem_wr) mem[mem_a] <= mem_din;
          else mem_dout <= mem[mem_a] ^
                 ((corrupt_en && (k - 1) == 1024 + int'(corrupt_addr)) ? 16'h0001 : 16'h0000);
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end else begin
      mem_done <= 1'b0;
      wcnt     <= 0;
    end
  end

  // Access monitor: logs every strobe rise and the longest strobe-high run.
  always @(negedge clk) begin
    prev_strobe <= mem_rd | mem_wr;
    if (clr) begin
      k       <= 0;
      max_len <= 0;
      obs_q.delete();
    end else if ((mem_rd || mem_wr) && !prev_strobe) begin
      k      <= k + 1;
      hi_len <= 1;
      obs_q.push_back({mem_rd, mem_wr, mem_a, mem_wr ? mem_din : 16'h0000});
    end else if (mem_rd || mem_wr) begin
      hi_len <= hi_len + 1;
    end else if (prev_strobe && hi_len > max_len) begin
      max_len <= hi_len;
    end
  end

  // Whole-test reference over a copy of the memory contents.
  task automatic ref_run();
    logic [15:0] rm [1024];
    logic [15:0] p, d;
    bit          bad;
    rm = mem;
    exp_q.delete();
    n_err = 0;
    faddr = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < 1024; a++) begin
        p = 16'hA5A5 ^ 16'(a);
        if (ph >= 2) p = ~p;
        bad = 1'b0;
        if (ph % 2 == 0) begin
          exp_q.push_back({2'b01, 10'(a), p});
          if (hang_en && ph == 0 && a == int'(hang_addr)) bad = 1'b1;
          else rm[a] = p;
        end else begin
          exp_q.push_back({2'b10, 10'(a), 16'h0000});
          d = rm[a];
          if (corrupt_en && ph == 1 && a == int'(corrupt_addr)) d = d ^ 16'h0001;
          bad = (d != p);
        end
        if (bad) begin
          if (n_err == 0) faddr = 10'(a);
          if (n_err < 65535) n_err++;
`ifndef MEM_TEST_ERRCNT_EN
          return;
`endif
        end
      end
    end
  endtask

  task automatic run_start(input bit with_rd);
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0; start = 1'b1; man_rd_req = with_rd;
    @(posedge clk); #1;
    check("start_busy", busy, 1);
    check("start_addr", mem_a, 0);
    check("start_strobe", {mem_rd, mem_wr}, 2'b01);
    check("start_clear", {done, pass, fail}, 3'b000);
    @(negedge clk); #1 start = 1'b0; man_rd_req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("done", done, 1);
  endtask

  task automatic self_test(input bit with_rd, input bit mid_req);
    logic [15:0] rd_before;
    int idx;
    rd_before = rd_data;
    ref_run();
    run_start(with_rd);
    if (mid_req) begin
      repeat (200) @(negedge clk);
      #1 man_addr = 10'($urandom); man_din = 16'($urandom); man_wr_req = 1'b1;
      @(negedge clk); #1 man_wr_req = 1'b0; man_rd_req = 1'b1;
      @(negedge clk); #1 man_rd_req = 1'b0;
    end
    wait_done();
    last_flags = {1'b1, n_err == 0, n_err != 0};
    check("busy_end", busy, 0);
    check("result_flags", {done, pass, fail}, last_flags);
    check("fail_addr", fail_addr, faddr);
`ifdef MEM_TEST_ERRCNT_EN
    check("err_count", err_count, n_err);
`else
    check("err_count", err_count, 0);
`endif
    check("rd_data_kept", rd_data, rd_before);
    check("access_count", obs_q.size(), exp_q.size());
    idx = exp_q.size() - 1;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin
        idx = i;
        break;
      end
    end
    check("access_seq", obs_q[idx], exp_q[idx]);
  endtask

  task automatic manual(input bit wr, input logic [9:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk); #1 man_addr = a; man_din = d;
    if (wr) man_wr_req = 1'b1; else man_rd_req = 1'b1;
    @(negedge clk); #1 man_wr_req = 1'b0; man_rd_req = 1'b0; man_addr = ~a; man_din = ~d;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("man_idle", busy, 0);
  endtask

  initial begin
    logic [9:0]  ra;
    logic [15:0] rdat;
    int n;
    ar = 1'b1; start = 1'b0; man_rd_req = 1'b0; man_wr_req = 1'b0;
    man_addr = '0; man_din = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", |{mem_a, mem_din, mem_rd, mem_wr, rd_data, busy, done,
                          pass, fail, fail_addr, err_count}, 0);
    #1 ar = 1'b0;

    manual(1'b1, 10'h2A, 16'h1234);
    manual(1'b0, 10'h2A, 16'h0000);
    check("man_rd_data", rd_data, 16'h1234);
    check("man_keeps_done", {done, pass, fail}, last_flags);

    self_test(1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = 10'($urandom);
      rdat = 16'($urandom);
      manual(1'b1, ra, rdat);
      manual(1'b0, ra, ~rdat);
      check("man_rand_rd", rd_data, rdat);
      check("man_rand_flags", {done, pass, fail}, last_flags);
    end

    corrupt_en = 1'b1; corrupt_addr = 10'h155;
    self_test(1'b0, 1'b0);
    corrupt_en = 1'b0;

    hang_en = 1'b1; hang_addr = 10'h003;
    self_test(1'b0, 1'b0);
    check("timeout_len", max_len, 255);
    hang_en = 1'b0;

    self_test(1'b1, 1'b1);

    ref_run();
    run_start(1'b0);
    n = 0;
    while (!(mem_rd && obs_q.size() > 1030) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("pre_ar_rd", mem_rd, 1);
    #2 ar = 1'b1;
    #1;
    check("ar_strobe", {mem_rd, mem_wr}, 2'b00);
    check("ar_outs", |{mem_a, mem_din, mem_rd, mem_wr, rd_data, busy, done,
                       pass, fail, fail_addr, err_count}, 0);
    @(negedge clk); #1 ar = 1'b0;
    last_flags = 3'b000;
    self_test(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
